// File: rtl/range_scheduler_pkg.sv
// Shared constants and FSM state encodings for the ultrasonic ranging path.
// State values keep the legacy numeric encodings so existing benches can decode them.
package range_scheduler_pkg;

  localparam int unsigned CLK_FREQ_HZ = 50_000_000;
  localparam int unsigned DIST_W_DEF  = 9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_ECHO = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_e;

endpackage

// File: rtl/range_scheduler_echo_sync.sv
// Two-flop synchronizer for the raw sensor echo, plus single-cycle rise/fall
// pulses derived from the synchronized level.
module echo_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  // [0],[1] form the synchronizer; [2] is the previous synchronized level.
  logic [2:0] sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= {sh_q[1:0], async_i};
    end
  end

  assign sync_o = sh_q[1];
  assign rise_o = sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/range_scheduler.sv
// Periodic ultrasonic trigger/echo sequencer: times the echo, converts to cm,
// flags timeouts and near hits. Define RANGE_AVG_EN for a 4-sample moving average.
module range_scheduler
  import range_scheduler_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned CYCLES_PER_CM  = 2900,
  parameter int unsigned TIMEOUT_CYCLES = 1_500_000,
  parameter int unsigned PERIOD_CYCLES  = 3_000_000,
  parameter int unsigned DIST_W         = DIST_W_DEF,
  parameter int unsigned CNT_W          = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic [DIST_W-1:0] threshold_i,
  input  logic              echo_i,
  output logic              trigger_o,
  output logic [DIST_W-1:0] dist_o,
  output logic              valid_o,
  output logic              timeout_o,
  output logic              near_o,
  output logic              busy_o
);

  localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CPC_LAST  = CNT_W'(CYCLES_PER_CM - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [DIST_W-1:0] DIST_MAX  = '1;
  localparam logic [DIST_W-1:0] DIST_ONE  = DIST_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  psc_q, psc_d;
  logic [DIST_W-1:0] dcnt_q, dcnt_d;

  logic              trig_q, valid_q, tmo_q, near_q;
  logic [DIST_W-1:0] dist_q;

  logic              echo_s, echo_rise, echo_fall;
  logic              sample_vld, tmo_evt, count_en;
  logic [CNT_W-1:0]  psc_base;
  logic [DIST_W-1:0] dcnt_base;
  logic [DIST_W-1:0] dist_new;

  echo_sync u_echo_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (echo_i),
    .sync_o  (echo_s),
    .rise_o  (echo_rise),
    .fall_o  (echo_fall)
  );

  // The rising-edge cycle itself is counted so the total equals the echo width.
  assign count_en  = ((state_q == ST_MEASURE) && echo_s) ||
                     ((state_q == ST_WAIT_ECHO) && echo_rise);
  assign psc_base  = (state_q == ST_MEASURE) ? psc_q  : '0;
  assign dcnt_base = (state_q == ST_MEASURE) ? dcnt_q : '0;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q + CNT_ONE;
    period_d   = (period_q == '1) ? period_q : period_q + CNT_ONE;
    psc_d      = psc_q;
    dcnt_d     = dcnt_q;
    sample_vld = 1'b0;
    tmo_evt    = 1'b0;

    if (count_en) begin
      if (psc_base == CPC_LAST) begin
        psc_d  = '0;
        dcnt_d = (dcnt_base == DIST_MAX) ? dcnt_base : dcnt_base + DIST_ONE;
      end else begin
        psc_d  = psc_base + CNT_ONE;
        dcnt_d = dcnt_base;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d  = ST_TRIG;
          phase_d  = '0;
          period_d = '0;
        end
      end
      ST_TRIG: begin
        if (phase_q == TRIG_LAST) begin
          state_d = ST_WAIT_ECHO;
          phase_d = '0;
        end
      end
      ST_WAIT_ECHO: begin
        // Edge-triggered entry makes a stale-high echo wait for a fresh rise.
        if (echo_rise) begin
          state_d = ST_MEASURE;
        end else if (phase_q == TMO_LAST) begin
          state_d = ST_HOLDOFF;
          tmo_evt = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (echo_fall) begin
          state_d    = ST_HOLDOFF;
          sample_vld = 1'b1;
        end else if (phase_q == TMO_LAST) begin
          state_d = ST_HOLDOFF;
          tmo_evt = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (period_q >= PER_LAST) begin
          if (enable_i) begin
            state_d  = ST_TRIG;
            phase_d  = '0;
            period_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef RANGE_AVG_EN
  logic [3:0][DIST_W-1:0] hist_q;
  logic [DIST_W+1:0]      sum_q, sum_d;
  logic                   primed_q;

  // First sample after reset fills the whole window so the average starts flat.
  always_comb begin
    if (primed_q) begin
      sum_d = sum_q - {2'b00, hist_q[3]} + {2'b00, dcnt_q};
    end else begin
      sum_d = {dcnt_q, 2'b00};
    end
  end

  assign dist_new = sum_d[DIST_W+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q   <= '0;
      sum_q    <= '0;
      primed_q <= 1'b0;
    end else if (sample_vld) begin
      hist_q   <= primed_q ? {hist_q[2:0], dcnt_q} : {4{dcnt_q}};
      sum_q    <= sum_d;
      primed_q <= 1'b1;
    end
  end
`else
  assign dist_new = dcnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      period_q <= '0;
      psc_q    <= '0;
      dcnt_q   <= '0;
      trig_q   <= 1'b0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
      near_q   <= 1'b0;
      dist_q   <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      period_q <= period_d;
      psc_q    <= psc_d;
      dcnt_q   <= dcnt_d;
      trig_q   <= (state_d == ST_TRIG);
      valid_q  <= sample_vld;
      tmo_q    <= tmo_evt;
      if (sample_vld) begin
        dist_q <= dist_new;
        near_q <= (dist_new <= threshold_i);
      end else if (tmo_evt) begin
        near_q <= 1'b0;
      end
    end
  end

  assign trigger_o = trig_q;
  assign dist_o    = dist_q;
  assign valid_o   = valid_q;
  assign timeout_o = tmo_q;
  assign near_o    = near_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_range_scheduler.sv
// Directed bench for range_scheduler with short sim timing parameters.
module tb_range_scheduler;

  localparam int unsigned DW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable_i = 1'b0;
  logic          echo_i = 1'b0;
  logic [DW-1:0] threshold_i = '0;
  logic          trigger_o, valid_o, timeout_o, near_o, busy_o;
  logic [DW-1:0] dist_o;

  range_scheduler #(
    .TRIG_CYCLES    (500),
    .CYCLES_PER_CM  (100),
    .TIMEOUT_CYCLES (5000),
    .PERIOD_CYCLES  (8000),
    .DIST_W         (DW),
    .CNT_W          (24)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable_i),
    .threshold_i (threshold_i),
    .echo_i      (echo_i),
    .trigger_o   (trigger_o),
    .dist_o      (dist_o),
    .valid_o     (valid_o),
    .timeout_o   (timeout_o),
    .near_o      (near_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned valid_cnt = 0;
  int unsigned trig_rise_cnt = 0;
  int unsigned overlap_cnt = 0;
  logic        trig_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o) valid_cnt++;
    if (trigger_o && !trig_prev) trig_rise_cnt++;
    trig_prev = trigger_o;
    if ((valid_o && timeout_o) || ((valid_o || timeout_o) && trigger_o)) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  int unsigned t_rise;

  task automatic wait_trig_rise(input string tag);
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (trigger_o) break;
    end
    check(tag, trigger_o, 1);
    t_rise = cyc;
  endtask

  task automatic wait_trig_fall(output int unsigned len);
    len = 1;
    while (trigger_o && len < 2000) begin
      @(negedge clk);
      if (trigger_o) len++;
    end
  endtask

  task automatic pulse_echo(input int unsigned w, output int unsigned lat);
    echo_i = 1'b1;
    repeat (w) @(negedge clk);
    echo_i = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!valid_o && lat < 20);
  endtask

  task automatic wait_timeout(output int unsigned k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!timeout_o && k < 6000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  int unsigned len, lat, k, v0, t0;
  int unsigned w6 [4] = '{800, 800, 1200, 1200};
`ifdef RANGE_AVG_EN
  int unsigned d6 [4] = '{8, 8, 9, 10};
  int unsigned n6 [4] = '{1, 1, 1, 0};
`else
  int unsigned d6 [4] = '{8, 8, 12, 12};
  int unsigned n6 [4] = '{1, 1, 0, 0};
`endif

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {trigger_o, busy_o, valid_o, timeout_o, near_o, dist_o}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_not_busy", busy_o, 0);

    // 1: 900-cycle echo, threshold 10
    threshold_i = 10;
    enable_i = 1'b1;
    wait_trig_rise("t1_trig_rise");
    wait_trig_fall(len);
    check("t1_trig_len", len, 500);
    repeat (20) @(negedge clk);
    v0 = valid_cnt;
    pulse_echo(900, lat);
    check("t1_latency", lat, 3);
    check("t1_dist", dist_o, 9);
    check("t1_near", near_o, 1);
    @(negedge clk);
    check("t1_valid_single", valid_o, 0);
    check("t1_valid_count", valid_cnt - v0, 1);

    // 2a: 899-cycle echo floors to 8, equal to threshold
    threshold_i = 8;
    wait_trig_rise("t2_trig_rise");
    wait_trig_fall(len);
    repeat (20) @(negedge clk);
    pulse_echo(899, lat);
    check("t2_latency", lat, 3);
    check("t2_dist", dist_o, 8);
    check("t2_near", near_o, 1);

    // 3: no echo
    wait_trig_rise("t3_trig_rise");
    wait_trig_fall(len);
    v0 = valid_cnt;
    wait_timeout(k);
    check("t3_timeout_delay", k, 5000);
    check("t3_near_cleared", near_o, 0);
    check("t3_dist_held", dist_o, 8);
    @(negedge clk);
    check("t3_timeout_single", timeout_o, 0);
    check("t3_no_valid", valid_cnt - v0, 0);

    // 4a: stale echo across trigger fall, then a fresh 700-cycle echo
    wait_trig_rise("t4a_trig_rise");
    echo_i = 1'b1;
    wait_trig_fall(len);
    repeat (300) @(negedge clk);
    echo_i = 1'b0;
    repeat (100) @(negedge clk);
    check("t4a_no_valid_on_stale", valid_cnt - v0, 0);
    pulse_echo(700, lat);
    check("t4a_latency", lat, 3);
    check("t4a_dist", dist_o, 7);
    check("t4a_near", near_o, 1);

    // 4b: echo held high throughout
    wait_trig_rise("t4b_trig_rise");
    echo_i = 1'b1;
    wait_trig_fall(len);
    v0 = valid_cnt;
    wait_timeout(k);
    check("t4b_timeout_delay", k, 5000);
    check("t4b_near_cleared", near_o, 0);
    echo_i = 1'b0;
    @(negedge clk);
    check("t4b_no_valid", valid_cnt - v0, 0);

    // 5: enable dropped mid-MEASURE
    wait_trig_rise("t5_trig_rise");
    t0 = t_rise;
    wait_trig_fall(len);
    repeat (20) @(negedge clk);
    echo_i = 1'b1;
    repeat (300) @(negedge clk);
    enable_i = 1'b0;
    repeat (600) @(negedge clk);
    echo_i = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!valid_o && lat < 20);
    check("t5_latency", lat, 3);
    check("t5_dist", dist_o, 9);
    check("t5_near", near_o, 0);
    v0 = trig_rise_cnt;
    k = 0;
    while (busy_o && k < 10000) begin
      @(negedge clk);
      k++;
    end
    check("t5_busy_fall_cycle", cyc - t0, 8000);
    repeat (1000) @(negedge clk);
    check("t5_no_retrigger", trig_rise_cnt - v0, 0);

    // 5b: reset mid-MEASURE
    enable_i = 1'b1;
    wait_trig_rise("t5b_trig_rise");
    wait_trig_fall(len);
    repeat (20) @(negedge clk);
    echo_i = 1'b1;
    repeat (200) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5b_reset_outputs", {trigger_o, busy_o, valid_o, timeout_o, near_o, dist_o}, 0);
    @(negedge clk);
    echo_i = 1'b0;
    repeat (4) @(negedge clk);
    v0 = valid_cnt;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t5b_no_valid", valid_cnt - v0, 0);

    // 6: sample sequence 8, 8, 12, 12 from a fresh reset
    threshold_i = 9;
    for (int i = 0; i < 4; i++) begin
      wait_trig_rise("t6_trig_rise");
      wait_trig_fall(len);
      repeat (20) @(negedge clk);
      pulse_echo(w6[i], lat);
      check("t6_latency", lat, 3);
      check($sformatf("t6_dist_%0d", i), dist_o, d6[i]);
      check($sformatf("t6_near_%0d", i), near_o, n6[i]);
    end

    check("no_output_overlap", overlap_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
